prog_cntr: RTL and testbench
============================

Name: prog_cntr

Overview:
Parametrised successor to the team's fixed-width event counter. It adds these features:
- programmable terminal value
- up/down direction
- synchronous parallel load
- three boundary modes: wrap, saturate, one-shot

Intended for UART baud-tick, bit-index and frame-gap counting, where a single block replaces ad-hoc counters plus their compare logic.

Parameters:
WIDTH, 4, counter/terminal/load width in bits (>=1)
RST_VAL, 0, value of cnt_out after hard reset, soft reset

Ports:
clk  input  1  rising-edge clock
hard_rst_n  input  1  asynchronous active-low reset
soft_rst  input  1  synchronous clear, active-high
load  input  1  synchronous load of load_val, active-high
load_val  input  WIDTH  value loaded on load
incr  input  1  count step enable for this cycle
dir  input  1  1 = up, 0 = down
mode  input  2  00 wrap, 01 saturate, 10 one-shot, 11 treated as wrap
term_val  input  WIDTH  up-count boundary; the down-count boundary is always 0
cnt_out  output  WIDTH  registered count
at_bound  output  1  combinational: cnt_out at the active boundary
wrap_pulse  output  1  registered one-cycle pulse after a wrap
done  output  1  registered, high in one-shot DONE state
busy  output  1  registered, high in one-shot RUN state
ovf_sticky  output  1  see Optional Feature

Behaviour:
Reset (asynchronous, hard_rst_n=0):
- cnt_out=RST_VAL, wrap_pulse=0, done=0, busy=0, ovf_sticky=0
- FSM=IDLE
- Asynchronous assertion, synchronous release; takes effect mid-count with no completion of the step in flight.

Priority per clock edge: soft_rst > load > incr.
- soft_rst: cnt_out=RST_VAL, FSM=IDLE, wrap_pulse=0.
- load: cnt_out=load_val, FSM=IDLE, wrap_pulse=0. load_val is not clipped to term_val.
- No incr: hold; wrap_pulse=0.

Boundary definition:
- Up: boundary reached when cnt_out >= term_val. Unsigned compare, so out-of-range loaded values behave as if at the boundary.
- Down: boundary reached when cnt_out == 0.
- at_bound = dir ? (cnt_out >= term_val) : (cnt_out == 0).

Step on incr, mode wrap (00/11):
- Not at boundary: cnt_out ±1.
- At boundary, up: cnt_out=0, wrap_pulse=1 next cycle.
- At boundary, down: cnt_out=term_val, wrap_pulse=1 next cycle.
- term_val=0, up: cnt_out stays 0 and wrap_pulse fires on every incr.

Step on incr, mode saturate (01):
- Not at boundary: ±1.
- At boundary: hold, no wrap_pulse.

Step on incr, mode one-shot (10), FSM IDLE/RUN/DONE:
- IDLE + incr, not at boundary: ±1. Go to DONE if the new value is at the boundary, else go to RUN.
- IDLE + incr, already at boundary: hold, go to DONE.
- RUN + incr: ±1. Go to DONE when the new value reaches the boundary.
- DONE: incr ignored, cnt_out holds. Exit only via soft_rst, load, hard reset, or a mode change.
- busy = (FSM==RUN); done = (FSM==DONE); both registered with the state.
- Any cycle with mode != 10: FSM forced to IDLE next edge, so done/busy drop one cycle later.

Arithmetic:
- WIDTH-bit unsigned; ±1 never leaves [0, 2^WIDTH-1].
- No natural overflow is possible because the boundary rules pre-empt it.

Direction change:
- dir and term_val are sampled every cycle; no state carries direction.

Optional Feature:
Macro: PROG_CNTR_OVF_STICKY_EN
- Defined: ovf_sticky is a registered flag.
  - Set on the edge that produces a wrap, or on an incr that is blocked at the boundary in saturate mode.
  - Cleared only by soft_rst, load or hard reset.
  - If set and clear happen on the same edge, clear wins.
- Undefined: ovf_sticky is tied to 0; the port remains so instantiations are identical.

Test Plan:
1. WIDTH=4, mode=00, dir=1, term_val=5, incr held 8 cycles from 0 -> cnt_out 1,2,3,4,5,0,1,2. wrap_pulse high only the cycle after 5->0.
2. mode=00, dir=0, term_val=9, load_val=1 loaded, then 3 incr -> cnt_out 1,0,9,8. One wrap_pulse after 0->9.
3. mode=01, dir=1, term_val=3, 6 incr from 0 -> 1,2,3,3,3,3. No wrap_pulse. at_bound=1 from the value 3 onward. ovf_sticky=1 after the 4th incr only with PROG_CNTR_OVF_STICKY_EN.
4. mode=10, dir=1, term_val=4, incr held from 0 -> busy=1 at 1..3, cnt_out=4 with done=1, busy=0. Further incr holds 4. load 2 -> done=0, IDLE, cnt_out=2.
5. Simultaneous soft_rst+load+incr with RST_VAL=0, load_val=7 -> cnt_out=0. load+incr only -> cnt_out=7.
6. hard_rst_n pulsed low asynchronously mid-count (cnt_out=3, one-shot RUN) -> cnt_out=RST_VAL, busy=0, done=0 immediately without a clock edge. Counting resumes from RST_VAL after release.

Source files
------------

// File: rtl/prog_cntr.sv
// prog_cntr: programmable up/down counter with wrap, saturate and one-shot boundary modes
//
// Optional build macro: PROG_CNTR_OVF_STICKY_EN enables the sticky overflow flag;
// without it ovf_sticky is tied low and the port list is unchanged.
//
// Ports:
//   clk        rising-edge clock
//   hard_rst_n asynchronous active-low reset (async assert, sync release)
//   soft_rst   synchronous clear to RST_VAL (highest priority)
//   load       synchronous load of load_val (beats incr)
//   load_val   value loaded on load, not clipped to term_val
//   incr       step enable for this cycle
//   dir        1 = count up, 0 = count down
//   mode       00 wrap, 01 saturate, 10 one-shot, 11 wrap
//   term_val   up-count boundary (down-count boundary is 0)
//   cnt_out    registered count
//   at_bound   combinational: cnt_out is at the active boundary
//   wrap_pulse registered one-cycle pulse after a wrap
//   done       one-shot finished
//   busy       one-shot running
//   ovf_sticky sticky wrap / blocked-saturate flag
module prog_cntr #(
   parameter int               WIDTH   = 4,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             hard_rst_n,
   input  logic             soft_rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             incr,
   input  logic             dir,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] term_val,
   output logic [WIDTH-1:0] cnt_out,
   output logic             at_bound,
   output logic             wrap_pulse,
   output logic             done,
   output logic             busy,
   output logic             ovf_sticky
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           r_state, w_state_nxt;
   logic [WIDTH-1:0] r_cnt, w_cnt_nxt, w_step;
   logic             r_wrap, w_wrap_nxt, w_step_bound;

   assign at_bound     = dir ? (r_cnt >= term_val) : (r_cnt == '0);
   assign w_step       = dir ? r_cnt + 1'b1 : r_cnt - 1'b1;
   // one-shot finishes on the edge whose new value lands on the boundary
   assign w_step_bound = dir ? (w_step >= term_val) : (w_step == '0);

   always_comb begin
      w_cnt_nxt   = r_cnt;
      // leaving one-shot mode always returns the FSM to IDLE
      w_state_nxt = (mode == 2'b10) ? r_state : IDLE;
      w_wrap_nxt  = 1'b0;
      if (soft_rst) begin
         w_cnt_nxt   = RST_VAL;
         w_state_nxt = IDLE;
      end else if (load) begin
         w_cnt_nxt   = load_val;
         w_state_nxt = IDLE;
      end else if (incr) begin
         case (mode)
            2'b01: w_cnt_nxt = at_bound ? r_cnt : w_step;
            2'b10: begin
               // a RUN count pushed onto the boundary by a dir/term_val change finishes without stepping
               if (r_state != DONE) begin
                  w_cnt_nxt   = at_bound ? r_cnt : w_step;
                  w_state_nxt = (at_bound || w_step_bound) ? DONE : RUN;
               end
            end
            default: begin
               w_cnt_nxt  = at_bound ? (dir ? '0 : term_val) : w_step;
               w_wrap_nxt = at_bound;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge hard_rst_n) begin
      if (!hard_rst_n) begin
         r_cnt   <= RST_VAL;
         r_state <= IDLE;
         r_wrap  <= 1'b0;
      end else begin
         r_cnt   <= w_cnt_nxt;
         r_state <= w_state_nxt;
         r_wrap  <= w_wrap_nxt;
      end
   end

   assign cnt_out    = r_cnt;
   assign wrap_pulse = r_wrap;
   assign busy       = (r_state == RUN);
   assign done       = (r_state == DONE);

`ifdef PROG_CNTR_OVF_STICKY_EN
   logic r_ovf, w_ovf_set;
   // any accepted incr at the boundary outside one-shot is either a wrap or a blocked saturate
   assign w_ovf_set = incr && !soft_rst && !load && at_bound && (mode != 2'b10);

   always_ff @(posedge clk or negedge hard_rst_n) begin
      if (!hard_rst_n) r_ovf <= 1'b0;
      else             r_ovf <= (soft_rst || load) ? 1'b0 : (r_ovf || w_ovf_set);
   end

   assign ovf_sticky = r_ovf;
`else
   assign ovf_sticky = 1'b0;
`endif
endmodule

// File: tb/tb_prog_cntr.sv
// tb_prog_cntr: directed self-checking bench for prog_cntr (WIDTH=4, RST_VAL=0)
module tb_prog_cntr;
   logic       clk = 1'b0;
   logic       hard_rst_n, soft_rst, load, incr, dir;
   logic [3:0] load_val, term_val, cnt_out;
   logic [1:0] mode;
   logic       at_bound, wrap_pulse, done, busy, ovf_sticky;
   int         checks = 0;
   int         errors = 0;

`ifdef PROG_CNTR_OVF_STICKY_EN
   localparam logic OVF = 1'b1;
`else
   localparam logic OVF = 1'b0;
`endif

   prog_cntr #(.WIDTH(4), .RST_VAL(4'd0)) dut (
      .clk(clk), .hard_rst_n(hard_rst_n), .soft_rst(soft_rst), .load(load),
      .load_val(load_val), .incr(incr), .dir(dir), .mode(mode), .term_val(term_val),
      .cnt_out(cnt_out), .at_bound(at_bound), .wrap_pulse(wrap_pulse),
      .done(done), .busy(busy), .ovf_sticky(ovf_sticky)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int c1[8] = '{1, 2, 3, 4, 5, 0, 1, 2};
      int w1[8] = '{0, 0, 0, 0, 0, 1, 0, 0};
      int b1[8] = '{0, 0, 0, 0, 1, 0, 0, 0};
      int c3[6] = '{1, 2, 3, 3, 3, 3};
      int c4[4] = '{1, 2, 3, 4};
      hard_rst_n = 1'b0; soft_rst = 1'b0; load = 1'b0; incr = 1'b0;
      dir = 1'b1; mode = 2'b00; load_val = 4'd0; term_val = 4'd5;
      #12;
      chk("rst_cnt", cnt_out, 0);
      chk("rst_wrap", wrap_pulse, 0);
      chk("rst_done", done, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ovf", ovf_sticky, 0);
      hard_rst_n = 1'b1;
      step();
      // wrap up, term 5
      incr = 1'b1;
      for (int k = 0; k < 8; k++) begin
         step();
         chk($sformatf("t1_cnt%0d", k), cnt_out, c1[k]);
         chk($sformatf("t1_wrap%0d", k), wrap_pulse, w1[k]);
         chk($sformatf("t1_bnd%0d", k), at_bound, b1[k]);
      end
      chk("t1_ovf", ovf_sticky, OVF);
      // wrap down, term 9
      dir = 1'b0; term_val = 4'd9; load = 1'b1; load_val = 4'd1; incr = 1'b0;
      step();
      chk("t2_load", cnt_out, 1);
      chk("t2_ovf_clr", ovf_sticky, 0);
      load = 1'b0; incr = 1'b1;
      step(); chk("t2_c0", cnt_out, 0); chk("t2_w0", wrap_pulse, 0);
      step(); chk("t2_c9", cnt_out, 9); chk("t2_w9", wrap_pulse, 1);
      step(); chk("t2_c8", cnt_out, 8); chk("t2_w8", wrap_pulse, 0);
      // saturate up, term 3
      mode = 2'b01; dir = 1'b1; term_val = 4'd3; soft_rst = 1'b1; incr = 1'b0;
      step();
      chk("t3_clr", cnt_out, 0);
      soft_rst = 1'b0; incr = 1'b1;
      for (int k = 0; k < 6; k++) begin
         step();
         chk($sformatf("t3_cnt%0d", k), cnt_out, c3[k]);
         chk($sformatf("t3_wrap%0d", k), wrap_pulse, 0);
         chk($sformatf("t3_bnd%0d", k), at_bound, k >= 2);
         chk($sformatf("t3_ovf%0d", k), ovf_sticky, (k >= 3) ? OVF : 1'b0);
      end
      // one-shot up, term 4
      mode = 2'b10; term_val = 4'd4; soft_rst = 1'b1; incr = 1'b0;
      step();
      chk("t4_clr", cnt_out, 0);
      chk("t4_clr_ovf", ovf_sticky, 0);
      soft_rst = 1'b0; incr = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         chk($sformatf("t4_cnt%0d", k), cnt_out, c4[k]);
         chk($sformatf("t4_busy%0d", k), busy, k < 3);
         chk($sformatf("t4_done%0d", k), done, k == 3);
      end
      step(); chk("t4_hold_cnt", cnt_out, 4); chk("t4_hold_done", done, 1);
      step(); chk("t4_hold_cnt2", cnt_out, 4); chk("t4_hold_ovf", ovf_sticky, 0);
      load = 1'b1; load_val = 4'd2; incr = 1'b0;
      step();
      chk("t4_ld_cnt", cnt_out, 2); chk("t4_ld_done", done, 0); chk("t4_ld_busy", busy, 0);
      load = 1'b0; incr = 1'b1;
      step(); chk("t4_rerun_cnt", cnt_out, 3); chk("t4_rerun_busy", busy, 1);
      mode = 2'b00; incr = 1'b0;
      step(); chk("t4_mode_busy", busy, 0); chk("t4_mode_cnt", cnt_out, 3);
      // priority
      soft_rst = 1'b1; load = 1'b1; load_val = 4'd7; incr = 1'b1;
      step(); chk("t5_all", cnt_out, 0);
      soft_rst = 1'b0;
      step(); chk("t5_ld_incr", cnt_out, 7);
      // term_val = 0 up: stays 0, pulses every incr
      load = 1'b0; term_val = 4'd0;
      step(); chk("t5_t0_c0", cnt_out, 0); chk("t5_t0_w0", wrap_pulse, 1);
      step(); chk("t5_t0_c1", cnt_out, 0); chk("t5_t0_w1", wrap_pulse, 1);
      // async reset mid one-shot run
      mode = 2'b10; term_val = 4'd9; soft_rst = 1'b1;
      step();
      soft_rst = 1'b0;
      step(); step(); step();
      chk("t6_pre_cnt", cnt_out, 3); chk("t6_pre_busy", busy, 1);
      #2 hard_rst_n = 1'b0;
      #1;
      chk("t6_async_cnt", cnt_out, 0);
      chk("t6_async_busy", busy, 0);
      chk("t6_async_done", done, 0);
      step();
      chk("t6_held_cnt", cnt_out, 0);
      #2 hard_rst_n = 1'b1;
      step(); chk("t6_resume_cnt", cnt_out, 1); chk("t6_resume_busy", busy, 1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
